// File: rtl/rssi_sampler.sv
// RSSI measurement controller: drives the serial ADC's en/shdn handshake, averages
// and peak-detects a window of 2^LOG2_N samples, and flags CCA busy for the MAC.
module rssi_sampler #(
    parameter int LOG2_N  = 3,   // legal range 0..5
    parameter int TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       shdn_req,
    input  logic [7:0] threshold,
    input  logic       adc_rdy,
    input  logic       adc_data_rdy,
    input  logic [7:0] adc_data,
    output logic       adc_en,
    output logic       adc_shdn,
    output logic       busy,
    output logic       result_valid,
    output logic [7:0] rssi_avg,
    output logic [7:0] rssi_max,
    output logic       cca_busy,
    output logic       conv_err
);
    localparam int SW = 8 + LOG2_N;
    localparam int CW = LOG2_N + 1;
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG2_N) - 1);
    // Abort when the counter would reach TIMEOUT, so conv_err lands TIMEOUT+1 cycles after adc_en.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, GAP, DONE, SLEEP} state_t;

    state_t        state_reg, state_next;
    logic          pend_reg, pend_next;
    logic [SW-1:0] sum_reg, sum_next;
    logic [7:0]    max_reg, max_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [TW-1:0] tcnt_reg, tcnt_next;
    logic          drdy_reg;
    logic          en_reg, en_next;
    logic          shdn_reg, shdn_next;
    logic          busy_reg, busy_next;
    logic          rv_reg, rv_next;
    logic [7:0]    avg_reg, avg_next;
    logic [7:0]    rmax_reg, rmax_next;
    logic          cca_reg, cca_next;
    logic          ce_reg, ce_next;
    logic          sample;
    logic [7:0]    new_avg;

    assign sample  = adc_data_rdy && !drdy_reg;
    assign new_avg = sum_reg[LOG2_N +: 8];

    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        sum_next   = sum_reg;
        max_next   = max_reg;
        cnt_next   = cnt_reg;
        tcnt_next  = tcnt_reg;
        en_next    = 1'b0;
        shdn_next  = 1'b0;
        rv_next    = 1'b0;
        ce_next    = 1'b0;
        avg_next   = avg_reg;
        rmax_next  = rmax_reg;
        cca_next   = cca_reg;
        case (state_reg)
            IDLE: begin
                pend_next = pend_reg | start;
                if (pend_reg && adc_rdy) begin
                    sum_next   = '0;
                    max_next   = '0;
                    cnt_next   = '0;
                    en_next    = 1'b1;
                    state_next = REQ;
                end else if (shdn_req && adc_rdy) begin
                    en_next    = 1'b1;
                    shdn_next  = 1'b1;
                    state_next = SLEEP;
                end
            end
            REQ: begin
                tcnt_next  = '0;
                state_next = WAIT;
            end
            WAIT: begin
                if (sample) begin
                    sum_next   = sum_reg + SW'(adc_data);
                    max_next   = (adc_data > max_reg) ? adc_data : max_reg;
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = (cnt_reg == LAST_CNT) ? DONE : GAP;
                end else if (tcnt_reg == TMO_LAST) begin
                    ce_next    = 1'b1;
                    pend_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (adc_rdy) begin
                    en_next    = 1'b1;
                    state_next = REQ;
                end
            end
            DONE: begin
                avg_next   = new_avg;
                rmax_next  = max_reg;
                cca_next   = (new_avg >= threshold);
                rv_next    = 1'b1;
                pend_next  = 1'b0;
                state_next = IDLE;
            end
            SLEEP: begin
                pend_next = pend_reg | start;
                shdn_next = 1'b1;
                if (!shdn_req) begin
                    shdn_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == REQ) || (state_next == WAIT) ||
                    (state_next == GAP) || (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pend_reg  <= 1'b0;
            sum_reg   <= '0;
            max_reg   <= '0;
            cnt_reg   <= '0;
            tcnt_reg  <= '0;
            drdy_reg  <= 1'b0;
            en_reg    <= 1'b0;
            shdn_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            rv_reg    <= 1'b0;
            avg_reg   <= '0;
            rmax_reg  <= '0;
            cca_reg   <= 1'b0;
            ce_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            sum_reg   <= sum_next;
            max_reg   <= max_next;
            cnt_reg   <= cnt_next;
            tcnt_reg  <= tcnt_next;
            drdy_reg  <= adc_data_rdy;
            en_reg    <= en_next;
            shdn_reg  <= shdn_next;
            busy_reg  <= busy_next;
            rv_reg    <= rv_next;
            avg_reg   <= avg_next;
            rmax_reg  <= rmax_next;
            cca_reg   <= cca_next;
            ce_reg    <= ce_next;
        end
    end

    assign adc_en       = en_reg;
    assign adc_shdn     = shdn_reg;
    assign busy         = busy_reg;
    assign result_valid = rv_reg;
    assign rssi_avg     = avg_reg;
    assign rssi_max     = rmax_reg;
    assign cca_busy     = cca_reg;
    assign conv_err     = ce_reg;

endmodule

// File: tb/tb_rssi_sampler.sv
// Self-checking bench for rssi_sampler with a behavioural serial-ADC model
// (17-cycle conversion, 3-cycle gap, shutdown with dummy wake conversion).
module tb_rssi_sampler;
    localparam int CONV_CYC = 17;
    localparam int GAP_CYC  = 3;
    localparam int M_IDLE = 0, M_CONV = 1, M_GAP = 2, M_SHDN = 3, M_DUMMY = 4;

    logic       clk = 1'b0;
    logic       reset, start, shdn_req, adc_rdy, adc_data_rdy;
    logic [7:0] threshold, adc_data;
    logic       adc_en, adc_shdn, busy, result_valid, cca_busy, conv_err;
    logic [7:0] rssi_avg, rssi_max;

    always #5 clk = ~clk;

    rssi_sampler #(.LOG2_N(3), .TIMEOUT(63)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .shdn_req     (shdn_req),
        .threshold    (threshold),
        .adc_rdy      (adc_rdy),
        .adc_data_rdy (adc_data_rdy),
        .adc_data     (adc_data),
        .adc_en       (adc_en),
        .adc_shdn     (adc_shdn),
        .busy         (busy),
        .result_valid (result_valid),
        .rssi_avg     (rssi_avg),
        .rssi_max     (rssi_max),
        .cca_busy     (cca_busy),
        .conv_err     (conv_err)
    );

    // ADC model
    logic            mdl_clr, mdl_nodata;
    logic [7:0][7:0] smp;
    int              m_st, m_cnt, m_idx;

    always @(posedge clk) begin
        if (mdl_clr) begin
            m_st <= M_IDLE; m_cnt <= 0; m_idx <= 0;
            adc_rdy <= 1'b1; adc_data_rdy <= 1'b0; adc_data <= 8'd0;
        end else begin
            case (m_st)
                M_IDLE: if (adc_en) begin
                    adc_rdy <= 1'b0; adc_data_rdy <= 1'b0; m_cnt <= CONV_CYC;
                    if (adc_shdn) begin m_st <= M_SHDN; m_idx <= 0; end
                    else m_st <= M_CONV;
                end
                M_CONV: if (m_cnt > 1) m_cnt <= m_cnt - 1;
                    else if (!mdl_nodata) begin
                        adc_data_rdy <= 1'b1; adc_data <= smp[m_idx[2:0]];
                        m_idx <= m_idx + 1; m_cnt <= GAP_CYC; m_st <= M_GAP;
                    end
                M_GAP: if (m_cnt > 1) m_cnt <= m_cnt - 1;
                    else begin adc_rdy <= 1'b1; m_st <= M_IDLE; end
                M_SHDN: if (!adc_shdn) begin m_cnt <= CONV_CYC; m_st <= M_DUMMY; end
                M_DUMMY: if (m_cnt > 1) m_cnt <= m_cnt - 1;
                    else begin adc_rdy <= 1'b1; m_st <= M_IDLE; end
                default: m_st <= M_IDLE;
            endcase
        end
    end

    // Output monitor (counts only ever grow; tests work with deltas)
    int         cyc = 0, en_cnt = 0, en_bad = 0, rv_cnt = 0, ce_cnt = 0, en_cyc = 0, ce_cyc = 0;
    logic [7:0] rv_avg = 8'd0, rv_max = 8'd0;
    logic       rv_cca = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (adc_en) begin
            en_cnt <= en_cnt + 1;
            en_cyc <= cyc;
            if (adc_rdy !== 1'b1) en_bad <= en_bad + 1;
        end
        if (result_valid) begin
            rv_cnt <= rv_cnt + 1;
            rv_avg <= rssi_avg; rv_max <= rssi_max; rv_cca <= cca_busy;
        end
        if (conv_err) begin
            ce_cnt <= ce_cnt + 1;
            ce_cyc <= cyc;
        end
    end

    typedef struct {
        logic [7:0][7:0] s;
        logic [7:0]      thr;
        logic [7:0]      avg;
        logic [7:0]      mx;
        logic            cca;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    int   checks = 0, errors = 0;

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0][7:0] s, input logic [7:0] thr,
                                input logic [7:0] avg, input logic [7:0] mx, input logic cca);
        vec_t v;
        v.s = s; v.thr = thr; v.avg = avg; v.mx = mx; v.cca = cca;
        return v;
    endfunction

    // which: 0 = result_valid count, 1 = conv_err count, 2 = adc_en count
    task automatic wait_cnt(input int which, input int target, input int limit, output bit ok);
        int cur;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            cur = (which == 0) ? rv_cnt : (which == 1) ? ce_cnt : en_cnt;
            if (cur >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic model_clear();
        repeat (5) tick();
        mdl_clr = 1'b1; tick(); mdl_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic check_result(input int v, input int en0, input int bad0, input int rv0);
        bit ok;
        wait_cnt(0, rv0 + 1, 1000, ok);
        chk("result_seen", ok, 1);
        chk("rssi_avg", rv_avg, vecs[v].avg);
        chk("rssi_max", rv_max, vecs[v].mx);
        chk("cca_busy", rv_cca, vecs[v].cca);
        repeat (30) tick();
        chk("result_count", rv_cnt - rv0, 1);
        chk("en_count", en_cnt - en0, 8);
        chk("en_without_rdy", en_bad - bad0, 0);
        chk("held_avg", rssi_avg, vecs[v].avg);
        chk("idle_busy", busy, 0);
        $display("window vec%0d: avg=%0d max=%0d cca=%0d en_pulses=%0d", v, rv_avg, rv_max, rv_cca, en_cnt - en0);
    endtask

    task automatic run_window(input int v);
        int en0, bad0, rv0;
        smp = vecs[v].s; threshold = vecs[v].thr;
        model_clear();
        en0 = en_cnt; bad0 = en_bad; rv0 = rv_cnt;
        pulse_start();
        tick();
        chk("busy_in_window", busy, 1);
        check_result(v, en0, bad0, rv0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=hang required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  en0, en1, bad0, rv0, ce0;
        bit  ok;
        reset = 1'b1; start = 1'b0; shdn_req = 1'b0; threshold = 8'd0;
        mdl_clr = 1'b1; mdl_nodata = 1'b0; smp = '0;

        vecs[0] = mk({8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 8'd40, 8'd45, 8'd80, 1'b1);
        vecs[1] = mk({8'd8, {7{8'd7}}}, 8'd7, 8'd7, 8'd8, 1'b1);
        vecs[2] = mk({8'd8, {7{8'd7}}}, 8'd8, 8'd7, 8'd8, 1'b0);
        vecs[3] = mk({8{8'd255}}, 8'd255, 8'd255, 8'd255, 1'b1);
        vecs[4] = mk({8'd60, 8'd1, 8'd99, 8'd0, 8'd17, 8'd250, 8'd3, 8'd100}, 8'd67, 8'd66, 8'd250, 1'b0);
        vecs[5] = mk({8{8'd0}}, 8'd0, 8'd0, 8'd0, 1'b1);
        vecs[6] = mk({{7{8'd1}}, 8'd200}, 8'd26, 8'd25, 8'd200, 1'b0);

        repeat (3) tick();
        chk("reset_outputs", {adc_en, adc_shdn, busy, result_valid, rssi_avg, rssi_max, cca_busy, conv_err}, 0);
        $display("reset: outputs=%0h", {adc_en, adc_shdn, busy, result_valid, rssi_avg, rssi_max, cca_busy, conv_err});
        reset = 1'b0; mdl_clr = 1'b0;
        repeat (3) tick();

        for (int v = 0; v < NV; v++) run_window(v);

        // Sleep entry, start while asleep, wake with dummy conversion
        smp = vecs[0].s; threshold = vecs[0].thr;
        en0 = en_cnt;
        shdn_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (adc_en) begin ok = 1'b1; break; end
        end
        chk("sleep_entry_en", ok, 1);
        chk("sleep_entry_shdn", adc_shdn, 1);
        tick();
        chk("sleep_en_low", adc_en, 0);
        chk("sleep_shdn_held", adc_shdn, 1);
        pulse_start();
        repeat (5) tick();
        chk("sleep_shdn_busy", {adc_shdn, busy}, 2'b10);
        chk("sleep_en_count", en_cnt - en0, 1);
        $display("sleep: shdn=%0d en_pulses=%0d", adc_shdn, en_cnt - en0);
        shdn_req = 1'b0;
        tick();
        chk("wake_shdn_low", adc_shdn, 0);
        en1 = en_cnt; bad0 = en_bad; rv0 = rv_cnt;
        repeat (10) tick();
        chk("wake_no_early_en", en_cnt - en1, 0);
        check_result(0, en1, bad0, rv0);

        // Timeout: ADC never raises data_rdy
        mdl_nodata = 1'b1;
        model_clear();
        en0 = en_cnt; rv0 = rv_cnt; ce0 = ce_cnt;
        pulse_start();
        wait_cnt(1, ce0 + 1, 300, ok);
        chk("timeout_seen", ok, 1);
        chk("timeout_latency", ce_cyc - en_cyc, 64);
        chk("timeout_no_result", rv_cnt - rv0, 0);
        chk("timeout_hold", {rssi_avg, rssi_max, cca_busy}, {8'd45, 8'd80, 1'b1});
        tick();
        chk("timeout_idle", busy, 0);
        repeat (5) tick();
        chk("timeout_single_err", ce_cnt - ce0, 1);
        chk("timeout_single_en", en_cnt - en0, 1);
        $display("timeout: conv_err after %0d cycles, avg=%0d max=%0d", ce_cyc - en_cyc, rssi_avg, rssi_max);
        mdl_nodata = 1'b0;
        model_clear();

        // Reset during the 4th WAIT, then a clean window
        smp = vecs[0].s; threshold = vecs[0].thr;
        en0 = en_cnt; rv0 = rv_cnt;
        pulse_start();
        wait_cnt(2, en0 + 4, 300, ok);
        chk("fourth_en_seen", ok, 1);
        repeat (5) tick();
        chk("mid_window_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("midreset_outputs", {adc_en, adc_shdn, busy, result_valid, rssi_avg, rssi_max, cca_busy, conv_err}, 0);
        mdl_clr = 1'b1;
        repeat (3) tick();
        reset = 1'b0; mdl_clr = 1'b0;
        repeat (20) tick();
        chk("midreset_no_result", rv_cnt - rv0, 0);
        $display("midreset: outputs cleared, results issued=%0d", rv_cnt - rv0);
        run_window(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rssi_sampler.md
# rssi_sampler

Measurement controller sitting directly downstream of the RSSI serial ADC interface. It issues conversion requests over that block's `en`/`shdn` handshake and collects 2^LOG2_N consecutive 8-bit samples. For each window it produces a mean, a peak and a clear-channel-assessment (CCA) busy flag for the MAC. It also sequences the ADC into and out of power-down on request.

## Interface
- `LOG2_N`, default 3: log2 of samples per window. The legal range is 0–5.
- `TIMEOUT`, default 63: maximum number of cycles to wait for a sample before aborting.

- `clk`  in  1  system clock, shared with the ADC interface.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that requests a measurement window.
- `shdn_req`  in  1  level signal; while high and idle, the ADC is held in power-down.
- `threshold`  in  8  CCA threshold.
- `adc_rdy`  in  1  ADC interface is idle and will accept `en`.
- `adc_data_rdy`  in  1  ADC sample valid. It is a level that stays high until the next `en`.
- `adc_data`  in  8  ADC sample.
- `adc_en`  out  1  conversion request pulse to the ADC.
- `adc_shdn`  out  1  power-down request to the ADC.
- `busy`  out  1  a window is in progress.
- `result_valid`  out  1  one-cycle pulse when results update.
- `rssi_avg`  out  8  window mean.
- `rssi_max`  out  8  window peak.
- `cca_busy`  out  1  `rssi_avg >= threshold`.
- `conv_err`  out  1  one-cycle pulse when a window is aborted by timeout.

## Operation
- State machine states: IDLE, REQ, WAIT, GAP, DONE, SLEEP.
- **IDLE**
  - A `start` pulse sets `pend`.
  - If `pend` and `adc_rdy`: clear `sum`, `max` and `cnt`, then go to REQ.
  - Otherwise, if `shdn_req` and `adc_rdy`: assert `adc_en` and `adc_shdn` together for 1 cycle, then go to SLEEP.
  - If `pend` and `shdn_req` are both present, `pend` wins.
- **REQ**
  - `adc_en`=1 for exactly 1 cycle with `adc_shdn`=0.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - A sample is taken on the rising edge of `adc_data_rdy` (the registered previous value was 0).
  - On a sample: `sum += adc_data`; `max = max(max, adc_data)`; `cnt++`.
  - If `cnt == 2^LOG2_N - 1` go to DONE, otherwise go to GAP.
  - If the timeout counter reaches `TIMEOUT` first: pulse `conv_err`, clear `pend`, go to IDLE. Result outputs are left unchanged.
- **GAP**
  - Wait for `adc_rdy`, then go to REQ.
  - The ADC asserts `adc_rdy` about 3 cycles after `data_rdy`.
- **DONE**
  - `rssi_avg = sum >> LOG2_N`, which is `sum[LOG2_N+7:LOG2_N]` (truncate, no rounding).
  - `rssi_max` = `max`.
  - `cca_busy` = (`rssi_avg` >= `threshold`). This uses the new average and the current `threshold`.
  - Pulse `result_valid`, clear `pend`, go to IDLE.
- **SLEEP**
  - `adc_shdn` is held at 1.
  - When `shdn_req` falls: `adc_shdn`=0, go to IDLE.
  - The ADC then runs one dummy conversion (no `data_rdy`) before raising `adc_rdy`.
  - A `start` received in SLEEP sets `pend`; it is serviced after wake.
- **Arithmetic:** `sum` is `8+LOG2_N` bits and cannot overflow. `cnt` is `LOG2_N+1` bits.
- `start` received in REQ/WAIT/GAP/DONE is ignored.
- `busy` = 1 in REQ, WAIT, GAP and DONE.

## Timing
- **Reset values:**
  - All outputs are 0, including `adc_en`=0 and `adc_shdn`=0.
  - `sum`, `max` and `cnt` are cleared and `pend` is cleared.
  - The state returns to IDLE.
- **Reset mid-window:** the window is discarded and no `result_valid` is issued.
- All outputs are registered.
- `adc_en` is never asserted unless `adc_rdy` was 1 in the cycle it was decided.
- `adc_data_rdy` is registered once for edge detection. `adc_data` is sampled in the same cycle the edge is detected.
- `result_valid`, `rssi_avg`, `rssi_max` and `cca_busy` update in the same cycle.
- **Latency per sample:** about 21 cycles, i.e. `en` to `data_rdy` about 17 plus the gap to `adc_rdy`.
- **Window length:** about `2^LOG2_N × 21` cycles.
- **Window of 1 (LOG2_N=0):** `rssi_avg` = `rssi_max` = the sample.

## Test plan
- **Basic window:** LOG2_N=3, `threshold`=40. The ADC model returns 10,20,…,80. Pulse `start`. Required:
  - exactly 8 `adc_en` pulses, each while `adc_rdy`=1;
  - `result_valid` once, with `rssi_avg`=45, `rssi_max`=80, `cca_busy`=1.
- **Truncation and threshold equality:** samples 7,7,7,7,7,7,7,8, `threshold`=7. Required: `rssi_avg`=7 and `cca_busy`=1. Repeat with `threshold`=8: `cca_busy`=0.
- **Saturation:** all samples 255. Required: `rssi_avg`=255, `rssi_max`=255, no wrap.
- **Sleep/wake:**
  - Raise `shdn_req` while idle. Required: one cycle with `adc_en`=`adc_shdn`=1, then `adc_shdn` stays 1.
  - Pulse `start` during SLEEP, then drop `shdn_req`. Required: `adc_shdn`=0; no `adc_en` until the ADC's dummy conversion completes and `adc_rdy`=1; then a normal window runs.
- **Timeout:** the ADC model never raises `data_rdy`. Required: `conv_err` pulses 64 cycles after `adc_en`, state returns to IDLE, previous results are held, and `result_valid`=0.
- **Reset mid-window:** assert `reset` during the 4th WAIT. Required: next cycle all outputs are 0. A following `start` produces a correct full 8-sample result.
